cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the single-issue RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the request/ready handshakes to instruction and data memory. It latches the decoder's classification flags and produces the write enables for the IR, PC, register file and data memory. It also tracks halt and fault conditions and keeps a retired-instruction count.

Parameters:
WAIT_LIMIT, 16, maximum cycles a memory request may wait for ready before FAULT (0 = timeout disabled)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock
rstd  in  1  synchronous active-low reset
run  in  1  enable; allows leaving IDLE and continuing to the next instruction
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction word valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store) qualifier, valid while dmem_req=1
dmem_ready  in  1  data access complete this cycle
dec_reg_we  in  1  decoder: instruction writes rd
dec_is_load  in  1  decoder: load instruction
dec_is_store  in  1  decoder: store instruction
dec_is_halt  in  1  decoder: halt instruction
dec_illegal  in  1  decoder: unrecognised opcode/funct
ir_we  out  1  capture instruction word into IR
pc_we  out  1  commit next PC
rf_we  out  1  register file write
wb_sel  out  1  writeback source: 0 = ALU, 1 = load data
state  out  3  current state encoding
halted  out  1  core halted (sticky)
fault  out  1  core faulted (sticky)
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (rstd=0 at a clk edge): state=IDLE, the wait counter, latched flags and retired are cleared to 0, and every output is 0. Reset takes priority in every state, including mid-handshake; any outstanding request is dropped with no completion.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: all enables are 0. Go to FETCH when run=1.
- FETCH: imem_req=1, held until imem_ready. In the cycle imem_ready=1, ir_we=1 (combinational) and the next state is DECODE.
- DECODE: lasts one cycle; latch dec_reg_we, dec_is_load and dec_is_store. Priority order:
  - dec_illegal -> FAULT
  - else dec_is_halt -> HALT
  - else -> EXEC
- EXEC: lasts one cycle. If the latched load or store flag is set -> MEM, else -> WB.
- MEM: dmem_req=1 and dmem_we=latched store, held until dmem_ready.
  - On dmem_ready with a load: -> WB.
  - On dmem_ready with a store: pc_we=1 and retired+1 in that cycle; next state is FETCH if run=1, else IDLE.
- WB: lasts one cycle. rf_we=latched reg_we, wb_sel=latched load, pc_we=1, retired+1. Next state is FETCH if run=1, else IDLE.
- Wait counter:
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle that the request is high and ready is 0.
  - If it reaches WAIT_LIMIT-1 and ready is still 0 -> FAULT next cycle.
  - A ready arriving on the limit cycle wins over the timeout.
- HALT: halted=1; all enables and requests are 0. Only reset leaves this state.
- FAULT: fault=1; all enables and requests are 0. Only reset leaves this state.
- Output decoding:
  - ir_we, pc_we, rf_we and dmem_req never assert outside the states listed above.
  - pc_we and rf_we are single-cycle pulses.
- retired saturates at 2^CNT_W-1 (no wrap).
- Latency with zero-wait memory, counted from entry to FETCH:
  - ALU instruction retires in cycle 4 (F, D, E, W).
  - Store retires in cycle 4 (F, D, E, M).
  - Load retires in cycle 5 (F, D, E, M, W).
- run is sampled only at IDLE and at the retire points. Deasserting run mid-instruction lets the current instruction complete.
- If dec_is_load and dec_is_store are both 1, the instruction is treated as a load (dmem_we=0).

Test Plan:
- ALU op, run=1, imem_ready tied 1: state follows 0,1,2,3,5,1. ir_we is 1 in FETCH, rf_we=1 and pc_we=1 in WB. retired goes 0->1 after 4 cycles.
- Load, dmem_ready delayed 3 cycles: dmem_req=1 and dmem_we=0 for 4 cycles. WB then has wb_sel=1 and rf_we=1. retired increments once.
- Store, dmem_ready immediate: dmem_we=1 in MEM and pc_we=1 in the same cycle. WB is never entered and rf_we stays 0.
- dec_is_halt=1 in DECODE: state=6 and halted=1 stays set while run toggles. Nothing further is fetched until rstd=0.
- Timeout with WAIT_LIMIT=4 and imem_ready held 0: fault=1 and state=7 after 4 FETCH cycles. With ready on the 4th cycle, DECODE is entered instead.
- rstd=0 during MEM while dmem_req=1: the next cycle has state=0, dmem_req=0, retired=0 and halted=fault=0.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and owns the memory handshakes and write enables.
module cpu_ctrl_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             dec_reg_we,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_halt,
  input  logic             dec_illegal,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam bit TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam int WAIT_MAX   = (WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0;
  localparam int WAIT_W     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  state_t             state_r;
  state_t             state_n_s;
  logic               reg_we_r;
  logic               load_r;
  logic               store_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [CNT_W-1:0]   retired_r;
  logic               timeout_s;
  logic               enter_wait_s;
  logic               waiting_s;

  assign timeout_s    = TIMEOUT_EN && (wait_cnt_r == WAIT_W'(WAIT_MAX));
  assign enter_wait_s = (state_n_s != state_r) && ((state_n_s == S_FETCH) || (state_n_s == S_MEM));
  assign waiting_s    = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!rstd) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Decoder classification latched in DECODE; a load+store combination is treated as a load
  always_ff @(posedge clk) begin
    if (!rstd) begin
      reg_we_r <= 1'b0;
      load_r   <= 1'b0;
      store_r  <= 1'b0;
    end else if (state_r == S_DECODE) begin
      reg_we_r <= dec_reg_we;
      load_r   <= dec_is_load;
      store_r  <= dec_is_store && !dec_is_load;
    end else begin
      reg_we_r <= reg_we_r;
      load_r   <= load_r;
      store_r  <= store_r;
    end
  end

  // Memory wait counter, restarted on every entry into a requesting state
  always_ff @(posedge clk) begin
    if (!rstd) begin
      wait_cnt_r <= '0;
    end else if (enter_wait_s) begin
      wait_cnt_r <= '0;
    end else if (waiting_s && (wait_cnt_r != '1)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Retired-instruction counter; pc_we marks exactly the retire points
  always_ff @(posedge clk) begin
    if (!rstd) begin
      retired_r <= '0;
    end else if (pc_we && (retired_r != '1)) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  // Next-state and handshake/enable decode
  always_comb begin
    state_n_s = state_r;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) state_n_s = S_FETCH;
        else     state_n_s = S_IDLE;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_n_s = S_DECODE;
        end else if (timeout_s) begin
          state_n_s = S_FAULT;
        end else begin
          state_n_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_illegal)      state_n_s = S_FAULT;
        else if (dec_is_halt) state_n_s = S_HALT;
        else                  state_n_s = S_EXEC;
      end
      S_EXEC: begin
        if (load_r || store_r) state_n_s = S_MEM;
        else                   state_n_s = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_r;
        if (dmem_ready) begin
          if (store_r) begin
            pc_we     = 1'b1;
            state_n_s = run ? S_FETCH : S_IDLE;
          end else begin
            state_n_s = S_WB;
          end
        end else if (timeout_s) begin
          state_n_s = S_FAULT;
        end else begin
          state_n_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we     = reg_we_r;
        wb_sel    = load_r;
        pc_we     = 1'b1;
        state_n_s = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_n_s = S_HALT;
      S_FAULT: state_n_s = S_FAULT;
      default: state_n_s = S_FAULT;
    endcase
  end

  assign state   = state_r;
  assign halted  = (state_r == S_HALT);
  assign fault   = (state_r == S_FAULT);
  assign retired = retired_r;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed testbench for cpu_ctrl_fsm with WAIT_LIMIT=4 and a 4-bit retire counter
// so that the timeout boundary and counter saturation are reachable quickly.
module tb_cpu_ctrl_fsm;

  localparam int WL = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstd = 1'b0;
  logic          run = 1'b0;
  logic          imem_req;
  logic          imem_ready = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ready = 1'b0;
  logic          dec_reg_we = 1'b0;
  logic          dec_is_load = 1'b0;
  logic          dec_is_store = 1'b0;
  logic          dec_is_halt = 1'b0;
  logic          dec_illegal = 1'b0;
  logic          ir_we;
  logic          pc_we;
  logic          rf_we;
  logic          wb_sel;
  logic [2:0]    state;
  logic          halted;
  logic          fault;
  logic [CW-1:0] retired;

  int vec_cnt = 0;
  int err_cnt = 0;

  cpu_ctrl_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rstd(rstd), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_halt(dec_is_halt), .dec_illegal(dec_illegal),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .state(state), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_reg_we = 1'b0; dec_is_load = 1'b0; dec_is_store = 1'b0;
    dec_is_halt = 1'b0; dec_illegal = 1'b0;
  endtask

  task automatic do_reset;
    rstd = 1'b0;
    clear_inputs();
    tick();
    tick();
    rstd = 1'b1;
  endtask

  task automatic test_reset;
    rstd = 1'b0; run = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    #1;
    vec_cnt++; if (state !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d exp 0", state); end
    vec_cnt++; if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel} !== 7'd0) begin
      err_cnt++; $display("FAIL reset_enables: got %b exp 0000000", {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, wb_sel}); end
    vec_cnt++; if ({halted, fault} !== 2'b00 || retired !== 4'd0) begin
      err_cnt++; $display("FAIL reset_status: got h=%0d f=%0d r=%0d exp 0 0 0", halted, fault, retired); end
    rstd = 1'b1; clear_inputs();
    tick();
    #1;
    vec_cnt++; if (state !== 3'd0 || imem_req !== 1'b0) begin
      err_cnt++; $display("FAIL idle_no_run: got st=%0d req=%0d exp 0 0", state, imem_req); end
  endtask

  task automatic test_alu;
    logic [2:0] exp_st [0:5];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_reg_we = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vec_cnt++; if (state !== exp_st[c]) begin err_cnt++; $display("FAIL alu_state c=%0d: got %0d exp %0d", c, state, exp_st[c]); end
      vec_cnt++; if (ir_we !== (c == 1 || c == 5)) begin err_cnt++; $display("FAIL alu_ir_we c=%0d: got %0d", c, ir_we); end
      vec_cnt++; if (rf_we !== (c == 4) || pc_we !== (c == 4) || wb_sel !== 1'b0) begin
        err_cnt++; $display("FAIL alu_wb c=%0d: got rf=%0d pc=%0d sel=%0d", c, rf_we, pc_we, wb_sel); end
      vec_cnt++; if (retired !== ((c == 5) ? 4'd1 : 4'd0)) begin err_cnt++; $display("FAIL alu_retired c=%0d: got %0d", c, retired); end
      tick();
    end
  endtask

  task automatic test_load;
    logic [2:0] exp_st [0:10];
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0, 3'd0};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_is_load = 1'b1; dec_reg_we = 1'b1;
    for (int c = 0; c < 11; c++) begin
      dmem_ready = (c == 7);
      run = (c < 8);
      #1;
      vec_cnt++; if (state !== exp_st[c]) begin err_cnt++; $display("FAIL load_state c=%0d: got %0d exp %0d", c, state, exp_st[c]); end
      vec_cnt++; if (dmem_req !== (c >= 4 && c <= 7) || dmem_we !== 1'b0) begin
        err_cnt++; $display("FAIL load_dmem c=%0d: got req=%0d we=%0d", c, dmem_req, dmem_we); end
      vec_cnt++; if (rf_we !== (c == 8) || wb_sel !== (c == 8) || pc_we !== (c == 8)) begin
        err_cnt++; $display("FAIL load_wb c=%0d: got rf=%0d sel=%0d pc=%0d", c, rf_we, wb_sel, pc_we); end
      vec_cnt++; if (retired !== ((c >= 9) ? 4'd1 : 4'd0)) begin err_cnt++; $display("FAIL load_retired c=%0d: got %0d", c, retired); end
      tick();
    end
  endtask

  task automatic test_store_back_to_back;
    logic [2:0] exp_st [0:9];
    logic [3:0] exp_ret;
    exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; dec_is_store = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_ret = (c >= 9) ? 4'd2 : ((c >= 5) ? 4'd1 : 4'd0);
      #1;
      vec_cnt++; if (state !== exp_st[c]) begin err_cnt++; $display("FAIL store_state c=%0d: got %0d exp %0d", c, state, exp_st[c]); end
      vec_cnt++; if (dmem_req !== (c == 4 || c == 8) || dmem_we !== (c == 4 || c == 8)) begin
        err_cnt++; $display("FAIL store_dmem c=%0d: got req=%0d we=%0d", c, dmem_req, dmem_we); end
      vec_cnt++; if (pc_we !== (c == 4 || c == 8) || rf_we !== 1'b0) begin
        err_cnt++; $display("FAIL store_pc c=%0d: got pc=%0d rf=%0d", c, pc_we, rf_we); end
      vec_cnt++; if (retired !== exp_ret) begin err_cnt++; $display("FAIL store_retired c=%0d: got %0d exp %0d", c, retired, exp_ret); end
      tick();
    end
  endtask

  task automatic test_load_store_both;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    dec_is_load = 1'b1; dec_is_store = 1'b1; dec_reg_we = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    #1;
    vec_cnt++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || pc_we !== 1'b0) begin
      err_cnt++; $display("FAIL both_mem: got st=%0d req=%0d we=%0d pc=%0d exp 4 1 0 0", state, dmem_req, dmem_we, pc_we); end
    tick();
    #1;
    vec_cnt++; if (state !== 3'd5 || wb_sel !== 1'b1 || rf_we !== 1'b1) begin
      err_cnt++; $display("FAIL both_wb: got st=%0d sel=%0d rf=%0d exp 5 1 1", state, wb_sel, rf_we); end
  endtask

  task automatic test_halt;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_is_halt = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 3) run = c[0];
      #1;
      vec_cnt++; if (state !== ((c >= 3) ? 3'd6 : 3'(c))) begin err_cnt++; $display("FAIL halt_state c=%0d: got %0d", c, state); end
      vec_cnt++; if (halted !== (c >= 3) || fault !== 1'b0) begin err_cnt++; $display("FAIL halt_flag c=%0d: got h=%0d f=%0d", c, halted, fault); end
      vec_cnt++; if (c >= 3 && {imem_req, dmem_req, ir_we, pc_we, rf_we} !== 5'd0) begin
        err_cnt++; $display("FAIL halt_quiet c=%0d: got %b exp 00000", c, {imem_req, dmem_req, ir_we, pc_we, rf_we}); end
      tick();
    end
    do_reset();
    #1;
    vec_cnt++; if (state !== 3'd0 || halted !== 1'b0) begin err_cnt++; $display("FAIL halt_reset: got st=%0d h=%0d exp 0 0", state, halted); end
  endtask

  task automatic test_illegal;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_illegal = 1'b1; dec_is_halt = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    #1;
    vec_cnt++; if (state !== 3'd7 || fault !== 1'b1 || halted !== 1'b0) begin
      err_cnt++; $display("FAIL illegal: got st=%0d f=%0d h=%0d exp 7 1 0", state, fault, halted); end
  endtask

  task automatic test_fetch_timeout;
    do_reset();
    run = 1'b1; imem_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #1;
      vec_cnt++; if (state !== ((c == 0) ? 3'd0 : ((c <= 4) ? 3'd1 : 3'd7))) begin
        err_cnt++; $display("FAIL ftimeout_state c=%0d: got %0d", c, state); end
      vec_cnt++; if (imem_req !== (c >= 1 && c <= 4) || fault !== (c >= 5)) begin
        err_cnt++; $display("FAIL ftimeout_out c=%0d: got req=%0d f=%0d", c, imem_req, fault); end
      tick();
    end
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 6; c++) begin
      imem_ready = (c == 4);
      #1;
      vec_cnt++; if (state !== ((c == 0) ? 3'd0 : ((c <= 4) ? 3'd1 : 3'd2))) begin
        err_cnt++; $display("FAIL fready_limit c=%0d: got %0d", c, state); end
      tick();
    end
  endtask

  task automatic test_mem_timeout;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_is_load = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    #1;
    vec_cnt++; if (state !== 3'd4 || dmem_req !== 1'b1) begin err_cnt++; $display("FAIL mtimeout_wait: got st=%0d req=%0d exp 4 1", state, dmem_req); end
    tick();
    #1;
    vec_cnt++; if (state !== 3'd7 || fault !== 1'b1 || dmem_req !== 1'b0) begin
      err_cnt++; $display("FAIL mtimeout: got st=%0d f=%0d req=%0d exp 7 1 0", state, fault, dmem_req); end
  endtask

  task automatic test_reset_mid_mem;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_reg_we = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    dec_is_load = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    #1;
    vec_cnt++; if (state !== 3'd4 || dmem_req !== 1'b1 || retired !== 4'd1) begin
      err_cnt++; $display("FAIL pre_reset_mem: got st=%0d req=%0d r=%0d exp 4 1 1", state, dmem_req, retired); end
    rstd = 1'b0;
    tick();
    #1;
    vec_cnt++; if (state !== 3'd0 || dmem_req !== 1'b0 || retired !== 4'd0 || halted !== 1'b0 || fault !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid_mem: got st=%0d req=%0d r=%0d h=%0d f=%0d exp 0 0 0 0 0", state, dmem_req, retired, halted, fault); end
    rstd = 1'b1;
  endtask

  task automatic test_saturate;
    int exp_ret;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; dec_reg_we = 1'b1;
    for (int c = 0; c < 72; c++) begin
      exp_ret = (c == 0) ? 0 : ((c - 1) / 4);
      if (exp_ret > 15) exp_ret = 15;
      #1;
      vec_cnt++; if (retired !== 4'(exp_ret)) begin err_cnt++; $display("FAIL sat_retired c=%0d: got %0d exp %0d", c, retired, exp_ret); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_back_to_back();
    test_load_store_both();
    test_halt();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_mem();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
